// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared interval/selector codes and default times for the traffic-light controller
package tlc_pkg;

    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam int T_BASE_DEFAULT = 6;
    localparam int T_EXT_DEFAULT  = 3;
    localparam int T_YEL_DEFAULT  = 2;

endpackage

// File: rtl/interval_timer_if.sv
// rtl/interval_timer_if.sv - FSM/operator side signals of the interval timer
interface interval_timer_if #(
    parameter int TW = 4
);
    logic          prog_sync;
    logic [1:0]    param_sel;
    logic [TW-1:0] time_value;
    logic [1:0]    interval;
    logic          start_t;
    logic          expired;
    logic [TW-1:0] remaining;
    logic          tick_1hz;

    modport master (
        output prog_sync, param_sel, time_value, interval, start_t,
        input  expired, remaining, tick_1hz
    );

    modport slave (
        input  prog_sync, param_sel, time_value, interval, start_t,
        output expired, remaining, tick_1hz
    );
endinterface

// File: rtl/interval_timer_one_hz_divider.sv
// rtl/interval_timer_one_hz_divider.sv - clock prescaler producing a one-second wrap strobe
module one_hz_divider #(
    parameter int CLK_HZ = 100_000_000,
    localparam int PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1
) (
    input  logic clk,
    input  logic reset_sync,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    // Strobe is combinational so the countdown steps on the very edge the prescaler wraps.
    assign tick = enable && !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - programmable seconds countdown with base/extended/yellow parameter slots
module interval_timer
    import tlc_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TW         = 4,
    parameter int T_BASE_DEF = T_BASE_DEFAULT,
    parameter int T_EXT_DEF  = T_EXT_DEFAULT,
    parameter int T_YEL_DEF  = T_YEL_DEFAULT
) (
    input logic              clk,
    input logic              reset_sync,
    interval_timer_if.slave  tif
);
    localparam logic [TW-1:0] BASE_DEF = TW'(T_BASE_DEF);
    localparam logic [TW-1:0] EXT_DEF  = TW'(T_EXT_DEF);
    localparam logic [TW-1:0] YEL_DEF  = TW'(T_YEL_DEF);

    logic [TW-1:0] base_q, base_d;
    logic [TW-1:0] ext_q, ext_d;
    logic [TW-1:0] yel_q, yel_d;
    logic [TW-1:0] count_q, count_d;
    logic          expired_q, expired_d;
    logic          tick_q, tick_d;
    logic          running;
    logic          wrap;

    assign running = (count_q != '0);

    one_hz_divider #(.CLK_HZ(CLK_HZ)) u_div (
        .clk        (clk),
        .reset_sync (reset_sync),
        .clear      (tif.start_t),
        .enable     (running),
        .tick       (wrap)
    );

    // A zero write falls back to the slot default so no interval can be zero-length.
    always_comb begin
        base_d = base_q;
        ext_d  = ext_q;
        yel_d  = yel_q;
        if (tif.prog_sync) begin
            case (tif.param_sel)
                SEL_BASE: base_d = (tif.time_value == '0) ? BASE_DEF : tif.time_value;
                SEL_EXT:  ext_d  = (tif.time_value == '0) ? EXT_DEF  : tif.time_value;
                SEL_YEL:  yel_d  = (tif.time_value == '0) ? YEL_DEF  : tif.time_value;
                default:  ;
            endcase
        end
    end

    always_comb begin
        count_d   = count_q;
        expired_d = 1'b0;
        tick_d    = 1'b0;
        if (tif.start_t) begin
            case (tif.interval)
                INT_EXT: count_d = ext_q;
                INT_YEL: count_d = yel_q;
                default: count_d = base_q;
            endcase
        end else if (wrap) begin
            tick_d = 1'b1;
            if (count_q == TW'(1)) begin
                count_d   = '0;
                expired_d = 1'b1;
            end else begin
                count_d = count_q - TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            base_q    <= BASE_DEF;
            ext_q     <= EXT_DEF;
            yel_q     <= YEL_DEF;
            count_q   <= '0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            base_q    <= base_d;
            ext_q     <= ext_d;
            yel_q     <= yel_d;
            count_q   <= count_d;
            expired_q <= expired_d;
            tick_q    <= tick_d;
        end
    end

    assign tif.expired   = expired_q;
    assign tif.remaining = count_q;
    assign tif.tick_1hz  = tick_q;

endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - scoreboard bench for interval_timer with a four-cycle second
module tb_interval_timer;
    import tlc_pkg::*;

    localparam int HZ = 4;

    logic clk = 1'b0;
    logic reset_sync;
    always #5 clk = ~clk;

    interval_timer_if #(.TW(4)) tif ();

    interval_timer #(.CLK_HZ(HZ), .TW(4)) dut (
        .clk        (clk),
        .reset_sync (reset_sync),
        .tif        (tif.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int tick_seen   = 0;
    int exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every expired pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (tif.tick_1hz) tick_seen++;
        if (!reset_sync && tif.expired) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_expired: got pulse at cycle %0d, expected none", cyc);
            end else begin
                check("expired_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    task automatic prog(input logic [1:0] sel, input logic [3:0] val);
        @(negedge clk);
        tif.prog_sync  = 1'b1;
        tif.param_sel  = sel;
        tif.time_value = val;
        @(posedge clk);
        #1;
        tif.prog_sync = 1'b0;
    endtask

    // A restart abandons any pending interval, so its expectation is dropped.
    task automatic start_timer(input logic [1:0] iv, input int n);
        @(negedge clk);
        tif.start_t  = 1'b1;
        tif.interval = iv;
        @(posedge clk);
        #1;
        tif.start_t = 1'b0;
        exp_q.delete();
        exp_q.push_back(cyc + n * HZ);
    endtask

    task automatic wait_done(input string name, input int budget);
        int b = 0;
        while (exp_q.size() != 0 && b < budget) begin
            @(posedge clk);
            b++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int b;
        reset_sync     = 1'b1;
        tif.prog_sync  = 1'b0;
        tif.param_sel  = 2'b00;
        tif.time_value = 4'd0;
        tif.interval   = 2'b00;
        tif.start_t    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_remaining", int'(tif.remaining), 0);
        check("rst_expired", int'(tif.expired), 0);
        check("rst_tick", int'(tif.tick_1hz), 0);
        @(negedge clk);
        reset_sync = 1'b0;

        // 1: default base, remaining steps 6..0, tick on each second boundary
        start_timer(INT_BASE, 6);
        check("t1_rem_start", int'(tif.remaining), 6);
        for (int k = 1; k <= 6; k++) begin
            repeat (HZ) @(posedge clk);
            #1;
            check("t1_rem_step", int'(tif.remaining), 6 - k);
            check("t1_tick", int'(tif.tick_1hz), 1);
        end
        wait_done("t1_done", 40);
        repeat (3) @(posedge clk);

        // 2: programmed extended = 5
        prog(SEL_EXT, 4'd5);
        start_timer(INT_EXT, 5);
        wait_done("t2_done", 40);

        // 3: zero write to yellow keeps default 2
        prog(SEL_YEL, 4'd0);
        start_timer(INT_YEL, 2);
        wait_done("t3_done", 40);

        // 4: restart at cycle 10 of a base count
        start_timer(INT_BASE, 6);
        repeat (9) @(posedge clk);
        start_timer(INT_YEL, 2);
        wait_done("t4_done", 40);
        repeat (10) @(posedge clk);

        // 5: reset mid-count reverts programmed base 9 and ext 5
        prog(SEL_BASE, 4'd9);
        start_timer(INT_BASE, 9);
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset_sync = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("t5_rem_reset", int'(tif.remaining), 0);
        check("t5_tick_reset", int'(tif.tick_1hz), 0);
        @(negedge clk);
        reset_sync = 1'b0;
        tick_seen  = 0;
        repeat (12) @(posedge clk);
        #1;
        check("t5_idle_ticks", tick_seen, 0);
        check("t5_idle_rem", int'(tif.remaining), 0);
        start_timer(INT_BASE, 6);
        wait_done("t5_base_default", 40);
        start_timer(INT_EXT, 3);
        wait_done("t5_ext_default", 40);

        // 6: sel 11 is a no-op, interval 11 is base, back-to-back restart
        prog(SEL_NONE, 4'd9);
        start_timer(2'b11, 6);
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (!tif.expired && b < 60);
        check("t6_first_seen", int'(tif.expired), 1);
        start_timer(2'b11, 6);
        wait_done("t6_second", 40);
        repeat (10) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Programmable countdown timer that sits directly beside the traffic-light controller FSM.
- Consumes the FSM's `interval` code and `start_t` pulse, counts whole seconds from the system clock, and returns a one-cycle `expired` pulse.
- Holds the three programmable time parameters (base, extended, yellow), which the operator loads through the synchronised program strobe.

Parameters:
- CLK_HZ, 100_000_000: clock cycles per one-second tick.
- TW, 4: width of time values and the seconds counter (maximum 15 s).
- T_BASE_DEF, 6: default base interval, in seconds.
- T_EXT_DEF, 3: default extended interval, in seconds.
- T_YEL_DEF, 2: default yellow interval, in seconds.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_sync  in  1  synchronous, active-high reset (already synchronised upstream).
- prog_sync  in  1  one-cycle program strobe; writes `time_value` into the slot chosen by `param_sel`.
- param_sel  in  2  slot select: 00 base, 01 extended, 10 yellow, 11 none.
- time_value  in  TW  new value in seconds.
- interval  in  2  interval code from the FSM: 00 base, 01 extended, 10 yellow, 11 treated as base.
- start_t  in  1  load-and-start pulse from the FSM.
- expired  out  1  one-cycle pulse when the loaded interval has elapsed.
- remaining  out  TW  seconds left; 0 when idle.
- tick_1hz  out  1  one-cycle prescaler tick, for debug and LEDs.

Behaviour:
- Reset. On a clock edge with `reset_sync`=1:
  - base, ext and yel return to their defaults.
  - count=0 and prescaler=0.
  - expired=0, tick_1hz=0, remaining=0.
  - All other inputs are ignored that cycle.
- Parameter write. With `prog_sync`=1 and `reset_sync`=0:
  - sel 00, 01 or 10 loads `time_value` into that slot at the next edge.
  - `time_value`=0 loads that slot's default instead; a zero-length interval is never stored.
  - sel 11 is a no-op.
  - A write does not disturb the counter. The FSM restarts timing itself with `start_t`.
- Selection. On `start_t`=1, `interval` is sampled in the same cycle and picks N:
  - 00 or 11 gives N=base; 01 gives N=ext; 10 gives N=yel.
  - A write and a `start_t` in the same cycle: `start_t` uses the pre-write slot value.
- Start.
  - `start_t` loads count=N and clears the prescaler.
  - `start_t` while already counting restarts the count; no expired is issued for the abandoned interval.
- Prescaler.
  - Free-runs 0..CLK_HZ-1 while count≠0.
  - Held at 0 while idle (count=0).
  - `tick_1hz`=1 in the cycle the prescaler wraps.
- Countdown.
  - On a tick with count>1: count decrements by 1.
  - On a tick with count==1: count becomes 0 and `expired` is registered high for exactly one cycle.
  - The result is that `expired` rises exactly N·CLK_HZ cycles after the edge that sampled `start_t`.
- Idle.
  - count=0 produces no further ticks and no further `expired` until the next `start_t`.
- Priority within one cycle: reset_sync > start_t > tick decrement. A parameter write is independent of the counter.
- FSM interaction. The FSM raises `start_t` in the cycle after it sees `expired`. The timer must accept back-to-back start/expire with no lost or duplicated pulse.
- Output timing. `remaining` is the registered count value. All outputs are registered; there are no combinational input-to-output paths.
- Widths.
  - Prescaler width is clog2(CLK_HZ).
  - Counter arithmetic is unsigned TW bits; it never underflows because count==0 is idle.

Decomposition:
- Package `tlc_pkg` holds:
  - interval codes INT_BASE=2'b00, INT_EXT=2'b01, INT_YEL=2'b10;
  - selector codes SEL_BASE, SEL_EXT, SEL_YEL;
  - the default-time constants, shared with the FSM.
- One sub-module, `one_hz_divider` (inputs clk, reset_sync, clear, enable; output tick), implements the prescaler.
- The parameter register file and countdown stay in `interval_timer`.

Test Plan (bench sets CLK_HZ=4):
1. Reset, then `start_t` with interval=00 → `expired` high for exactly 1 cycle, 24 cycles after the start edge; `remaining` steps 6,5,…,1,0.
2. `prog_sync`, sel=01, value=5, then `start_t` with interval=01 → `expired` 20 cycles later.
3. `prog_sync`, sel=10, value=0, then `start_t` with interval=10 → yellow stays 2; `expired` at 8 cycles.
4. `start_t` interval=00, then at cycle 10 `start_t` interval=10 → no `expired` at 24; a single `expired` 8 cycles after the second start.
5. `reset_sync` at cycle 12 of a base count → `expired` never asserts; `remaining`=0; prescaler held; earlier programmed values revert to defaults.
6. Write with sel=11, value=9, then `start_t` interval=11 → base unchanged (6); `expired` at 24; repeat the start on the cycle after `expired` → a second `expired` exactly 24 cycles later, with no gap pulse.
